// File: rtl/vpu_norm_pkg.sv
`default_nettype none
// ============================================================================
// vpu_norm_pkg : shared types, sizing helpers and default configuration
//                for the iterative mantissa normalizer
// Revision     : 1.0
// ============================================================================
package vpu_norm_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int WIDTH_DEF = 64;
    localparam int CHUNK_DEF = 16;

    function automatic int vpu_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic bit vpu_cfg_ok(input int w, input int c);
        return (c >= 2) && ((c & (c - 1)) == 0) && ((w % c) == 0);
    endfunction

    localparam int NUM_CHUNKS = WIDTH_DEF / CHUNK_DEF;
    localparam int IDX_W      = vpu_idx_w(NUM_CHUNKS);
    localparam int CNT_W      = $clog2(WIDTH_DEF + 1);

endpackage
`default_nettype wire

// File: rtl/lzc.sv
`default_nettype none
// ============================================================================
// lzc      : combinational leading/trailing zero counter (MODE=1 leading)
// Revision : 1.0
// ============================================================================
module lzc #(
    parameter int WIDTH = 16,
    parameter int MODE  = 1
) (
    input  logic [WIDTH-1:0]         in_i,
    output logic [$clog2(WIDTH)-1:0] cnt_o,
    output logic                     empty_o
);

    localparam int c_cw = $clog2(WIDTH);

    // Later hits override earlier ones, so scan order picks the winning bit.
    always_comb begin
        cnt_o   = '0;
        empty_o = 1'b1;
        for (int i = 0; i < WIDTH; i++) begin
            if (MODE != 0) begin
                if (in_i[i]) begin
                    cnt_o   = c_cw'(WIDTH - 1 - i);
                    empty_o = 1'b0;
                end
            end else begin
                if (in_i[WIDTH-1-i]) begin
                    cnt_o   = c_cw'(WIDTH - 1 - i);
                    empty_o = 1'b0;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/vpu_norm_seq.sv
`default_nettype none
// ============================================================================
// vpu_norm_seq : iterative mantissa normalizer, CHUNK bits scanned per cycle
//                through one shared LZC, then a single-cycle shift/adjust
// Revision     : 1.0
// ============================================================================
module vpu_norm_seq
    import vpu_norm_pkg::*;
#(
    parameter int WIDTH     = WIDTH_DEF,
    parameter int CHUNK     = CHUNK_DEF,
    parameter int EXP_WIDTH = 13,
    parameter int TAG_WIDTH = 4
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       flush_i,
    input  logic                       in_valid_i,
    output logic                       in_ready_o,
    input  logic [WIDTH-1:0]           in_mant_i,
    input  logic [EXP_WIDTH-1:0]       in_exp_i,
    input  logic [TAG_WIDTH-1:0]       in_tag_i,
    output logic                       out_valid_o,
    input  logic                       out_ready_i,
    output logic [WIDTH-1:0]           out_mant_o,
    output logic [EXP_WIDTH-1:0]       out_exp_o,
    output logic [$clog2(WIDTH+1)-1:0] out_lzc_o,
    output logic                       out_zero_o,
    output logic [TAG_WIDTH-1:0]       out_tag_o,
    output logic                       busy_o
);

    localparam int c_num_chunks = WIDTH / CHUNK;
    localparam int c_idx_w      = vpu_idx_w(c_num_chunks);
    localparam int c_cnt_w      = $clog2(WIDTH + 1);
    localparam int c_lzc_w      = $clog2(CHUNK);

    if (!vpu_cfg_ok(WIDTH, CHUNK)) begin : g_cfg_check
        $error("vpu_norm_seq: WIDTH must be a multiple of CHUNK, CHUNK a power of two >= 2");
    end

    state_t               r_state;
    state_t               w_state_next;
    logic [WIDTH-1:0]     r_mant;
    logic [EXP_WIDTH-1:0] r_exp;
    logic [TAG_WIDTH-1:0] r_tag;
    logic [c_idx_w-1:0]   r_idx;
    logic [c_cnt_w-1:0]   r_cnt;
    logic                 r_zero;
    logic [CHUNK-1:0]     w_chunk;
    logic [c_lzc_w-1:0]   w_lzc_cnt;
    logic                 w_lzc_empty;
    logic                 w_accept;
    logic                 w_last_chunk;

    assign w_accept     = (r_state == IDLE) && in_valid_i && !flush_i;
    assign w_last_chunk = (r_idx == c_idx_w'(c_num_chunks - 1));

    // Chunk 0 is the most significant slice of the mantissa.
    always_comb begin
        w_chunk = CHUNK'(r_mant >> (CHUNK * (c_num_chunks - 1 - int'(r_idx))));
    end

    lzc #(
        .WIDTH (CHUNK),
        .MODE  (1)
    ) u_lzc (
        .in_i    (w_chunk),
        .cnt_o   (w_lzc_cnt),
        .empty_o (w_lzc_empty)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_state_next = SCAN;
            SCAN: begin
                if (!w_lzc_empty)     w_state_next = SHIFT;
                else if (w_last_chunk) w_state_next = DONE;
            end
            SHIFT:   w_state_next = DONE;
            DONE:    if (out_ready_i) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
        if (flush_i) begin
            w_state_next = IDLE;
        end
    end

    always_comb begin
        in_ready_o  = (r_state == IDLE) && !rst_i;
        out_valid_o = (r_state == DONE) && !rst_i;
        busy_o      = (r_state != IDLE) && !rst_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_mant <= '0;
            r_exp  <= '0;
            r_tag  <= '0;
            r_idx  <= '0;
            r_cnt  <= '0;
            r_zero <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_mant <= in_mant_i;
                        r_exp  <= in_exp_i;
                        r_tag  <= in_tag_i;
                        r_idx  <= '0;
                        r_cnt  <= '0;
                        r_zero <= 1'b0;
                    end
                end
                SCAN: begin
                    if (!w_lzc_empty) begin
                        r_cnt <= r_cnt + c_cnt_w'(w_lzc_cnt);
                    end else if (!w_last_chunk) begin
                        r_cnt <= r_cnt + c_cnt_w'(CHUNK);
                        r_idx <= r_idx + c_idx_w'(1);
                    end else begin
                        r_cnt  <= c_cnt_w'(WIDTH);
                        r_zero <= 1'b1;
                        r_mant <= '0;
                    end
                end
                // Exponent wraps modulo 2^EXP_WIDTH; range handling is downstream.
                SHIFT: begin
                    r_mant <= r_mant << r_cnt;
                    r_exp  <= r_exp - EXP_WIDTH'(r_cnt);
                end
                default: ;
            endcase
        end
    end

    assign out_mant_o = r_mant;
    assign out_exp_o  = r_exp;
    assign out_lzc_o  = r_cnt;
    assign out_zero_o = r_zero;
    assign out_tag_o  = r_tag;

endmodule
`default_nettype wire

// File: tb/tb_vpu_norm_seq.sv
`default_nettype none
// ============================================================================
// tb_vpu_norm_seq : directed self-checking bench for vpu_norm_seq
// Revision        : 1.0
// ============================================================================
module tb_vpu_norm_seq;
    import vpu_norm_pkg::*;

    localparam int W  = 64;
    localparam int C  = 16;
    localparam int EW = 13;
    localparam int TW = 4;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           flush = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [W-1:0]   in_mant = '0;
    logic [EW-1:0]  in_exp = '0;
    logic [TW-1:0]  in_tag = '0;
    logic           out_valid;
    logic           out_ready = 1'b0;
    logic [W-1:0]   out_mant;
    logic [EW-1:0]  out_exp;
    logic [CNT_W-1:0] out_lzc;
    logic           out_zero;
    logic [TW-1:0]  out_tag;
    logic           busy;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    vpu_norm_seq #(
        .WIDTH(W), .CHUNK(C), .EXP_WIDTH(EW), .TAG_WIDTH(TW)
    ) dut (
        .clk_i(clk), .rst_i(rst), .flush_i(flush),
        .in_valid_i(in_valid), .in_ready_o(in_ready),
        .in_mant_i(in_mant), .in_exp_i(in_exp), .in_tag_i(in_tag),
        .out_valid_o(out_valid), .out_ready_i(out_ready),
        .out_mant_o(out_mant), .out_exp_o(out_exp), .out_lzc_o(out_lzc),
        .out_zero_o(out_zero), .out_tag_o(out_tag), .busy_o(busy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic chk_result(input string tag, input logic [W-1:0] m, input logic [EW-1:0] e,
                              input int lz, input logic z, input logic [TW-1:0] t);
        chk({tag, ".mant"}, out_mant, m);
        chk({tag, ".exp"},  64'(out_exp), 64'(e));
        chk({tag, ".lzc"},  64'(out_lzc), 64'(lz));
        chk({tag, ".zero"}, 64'(out_zero), 64'(z));
        chk({tag, ".tag"},  64'(out_tag), 64'(t));
    endtask

    // Presents one operand; returns #1 after the accept edge.
    task automatic start_op(input string tag, input logic [W-1:0] m, input logic [EW-1:0] e,
                            input logic [TW-1:0] t);
        in_valid = 1'b1;
        in_mant  = m;
        in_exp   = e;
        in_tag   = t;
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk({tag, ".busy"},     64'(busy), 64'd1);
        chk({tag, ".in_ready"}, 64'(in_ready), 64'd0);
    endtask

    // Accept edge counts as cycle 1.
    task automatic wait_valid(input string tag, input int lat);
        int n = 1;
        while (!out_valid && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        chk({tag, ".latency"}, 64'(n), 64'(lat));
    endtask

    task automatic handshake(input string tag);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({tag, ".ready_after"}, 64'(in_ready), 64'd1);
        chk({tag, ".valid_after"}, 64'(out_valid), 64'd0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst.valid",    64'(out_valid), 64'd0);
        chk("rst.in_ready", 64'(in_ready),  64'd0);
        chk("rst.busy",     64'(busy),      64'd0);
        chk_result("rst", '0, '0, 0, 1'b0, '0);
        rst = 1'b0;
        #1;
        chk("rst.release_ready", 64'(in_ready), 64'd1);

        // Leading one already at the MSB
        start_op("a", 64'h8000_0000_0000_0000, 13'd100, 4'd1);
        wait_valid("a", 3);
        chk_result("a", 64'h8000_0000_0000_0000, 13'd100, 0, 1'b0, 4'd1);
        handshake("a");

        start_op("b", 64'h0000_0000_0001_0000, 13'd100, 4'd5);
        wait_valid("b", 5);
        chk_result("b", 64'h8000_0000_0000_0000, 13'd53, 47, 1'b0, 4'd5);
        handshake("b");

        // All-zero mantissa, exponent -7 preserved
        start_op("c", 64'h0, 13'h1FF9, 4'd2);
        wait_valid("c", NUM_CHUNKS + 1);
        chk_result("c", 64'h0, 13'h1FF9, 64, 1'b1, 4'd2);
        handshake("c");

        // -4090 - 63 = -4153 wraps to 4039
        start_op("d", 64'h1, 13'h1006, 4'd3);
        wait_valid("d", 6);
        chk_result("d", 64'h8000_0000_0000_0000, 13'h0FC7, 63, 1'b0, 4'd3);
        handshake("d");

        // Flush together with an offered operand: nothing latched
        in_valid = 1'b1;
        in_mant  = 64'h0000_0000_0000_00FF;
        in_tag   = 4'hF;
        flush    = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        flush    = 1'b0;
        chk("fa.busy",     64'(busy), 64'd0);
        chk("fa.in_ready", 64'(in_ready), 64'd1);
        chk("fa.tag_kept", 64'(out_tag), 64'd3);
        chk("fa.mant_kept", out_mant, 64'h8000_0000_0000_0000);

        // Result stalled by out_ready low for 4 cycles
        start_op("e", 64'h0000_3000_0000_0000, 13'd20, 4'd9);
        wait_valid("e", 4);
        chk_result("e", 64'hC000_0000_0000_0000, 13'd2, 18, 1'b0, 4'd9);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk("e.stall_valid",    64'(out_valid), 64'd1);
            chk("e.stall_in_ready", 64'(in_ready),  64'd0);
            chk("e.stall_mant",     out_mant, 64'hC000_0000_0000_0000);
            chk("e.stall_exp",      64'(out_exp), 64'd2);
        end
        handshake("e");

        // Back-to-back operand offered on the first idle cycle
        start_op("a2", 64'h8000_0000_0000_0000, 13'd100, 4'd1);
        wait_valid("a2", 3);
        chk_result("a2", 64'h8000_0000_0000_0000, 13'd100, 0, 1'b0, 4'd1);
        handshake("a2");

        // Flush during the second scan cycle of a zero operand
        start_op("f", 64'h0, 13'd0, 4'd4);
        @(posedge clk); #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("f.valid",    64'(out_valid), 64'd0);
        chk("f.in_ready", 64'(in_ready),  64'd1);
        chk("f.busy",     64'(busy),      64'd0);
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("f.no_valid", 64'(out_valid), 64'd0);
        end

        // Reset pulsed while in SHIFT
        start_op("r", 64'h0000_0000_0001_0000, 13'd100, 4'hA);
        repeat (3) @(posedge clk);
        #1;
        chk("r.busy_shift",  64'(busy), 64'd1);
        chk("r.valid_shift", 64'(out_valid), 64'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("r.valid",    64'(out_valid), 64'd0);
        chk("r.in_ready", 64'(in_ready),  64'd0);
        chk("r.busy",     64'(busy),      64'd0);
        chk_result("r", '0, '0, 0, 1'b0, '0);
        rst = 1'b0;
        #1;
        chk("r.ready_release", 64'(in_ready), 64'd1);

        start_op("b2", 64'h0000_0000_0001_0000, 13'd100, 4'd5);
        wait_valid("b2", 5);
        chk_result("b2", 64'h8000_0000_0000_0000, 13'd53, 47, 1'b0, 4'd5);
        handshake("b2");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
